// File: rtl/triumph_decode_pipe_pkg.sv
// Shared decode types and opcode constants for the triumph RV32I decode stage.
// Optional WB bypass is built in when TRIUMPH_ID_WB_BYPASS_EN is defined.
package triumph_decode_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    INSTR_R = 3'd0,
    INSTR_I = 3'd1,
    INSTR_S = 3'd2,
    INSTR_B = 3'd3,
    INSTR_U = 3'd4,
    INSTR_J = 3'd5
  } instr_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

  // op_type = {alt, funct3, opcode[6:4]}
  function automatic logic [6:0] op_type_f(
    input logic [31:0] instr,
    input instr_type_e itype
  );
    logic alt;
    alt = 1'b0;
    if (itype == INSTR_R)
      alt = instr[30];
    else if (itype == INSTR_I && instr[14:12] == 3'b101)
      alt = instr[30];
    return {alt, instr[14:12], instr[6:4]};
  endfunction

endpackage

// File: rtl/triumph_decode_pipe_imm_gen.sv
// Immediate generator: instruction word + format -> sign-extended XLEN
// immediate (zero for R-type).
module triumph_imm_gen
  import triumph_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  instr_type_e     itype,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opc;

  assign unused_opc = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    unique case (itype)
      INSTR_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      INSTR_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      INSTR_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      INSTR_U: imm32 = {instr[31:12], 12'b0};
      INSTR_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/triumph_decode_pipe.sv
// RV32I decode stage with load-use stall, flush and one held ID->EX entry.
// Define TRIUMPH_ID_WB_BYPASS_EN to forward WB data into the operands.
module triumph_decode_pipe
  import triumph_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_ready_o,
  output logic [RA_W-1:0] rf_rs1_addr_o,
  output logic [RA_W-1:0] rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ex_load_i,
  input  logic [RA_W-1:0] ex_load_rd_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_rd_we_o,
  output logic [2:0]      ex_instr_type_o,
  output logic [6:0]      ex_op_type_o,
  output logic            ex_illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd;
    logic            rd_we;
    logic [2:0]      itype;
    logic [6:0]      op_type;
    logic            illegal;
  } id_ex_t;

  localparam logic [5:0] NREG6 = 6'(NREG);

  hold_state_e     state;
  id_ex_t          entry;
  id_ex_t          dec;
  instr_type_e     itype;
  logic            known;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_used;
  logic            idx_bad;
  logic            hazard;
  logic            accept;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [4:0]      rd_f;
  logic [RA_W-1:0] rs1_a;
  logic [RA_W-1:0] rs2_a;
  logic [XLEN-1:0] imm;
  logic [6:0]      opc;

  assign opc   = if_instr_i[6:0];
  assign rs1_f = if_instr_i[19:15];
  assign rs2_f = if_instr_i[24:20];
  assign rd_f  = if_instr_i[11:7];
  assign rs1_a = rs1_f[RA_W-1:0];
  assign rs2_a = rs2_f[RA_W-1:0];

  assign rf_rs1_addr_o = rs1_a;
  assign rf_rs2_addr_o = rs2_a;

  always_comb begin
    itype = INSTR_R;
    known = 1'b1;
    unique case (1'b1)
      opc == OPC_OP:     itype = INSTR_R;
      opc == OPC_OP_IMM,
      opc == OPC_LOAD,
      opc == OPC_JALR,
      opc == OPC_SYSTEM: itype = INSTR_I;
      opc == OPC_STORE:  itype = INSTR_S;
      opc == OPC_BRANCH: itype = INSTR_B;
      opc == OPC_LUI,
      opc == OPC_AUIPC:  itype = INSTR_U;
      opc == OPC_JAL:    itype = INSTR_J;
      default:           known = 1'b0;
    endcase
  end

  // Unknown opcodes claim no registers, so they never stall.
  assign rs1_used = known & (itype != INSTR_U) & (itype != INSTR_J);
  assign rs2_used = known & ((itype == INSTR_R) | (itype == INSTR_S) |
                             (itype == INSTR_B));
  assign rd_used  = known & (itype != INSTR_S) & (itype != INSTR_B);

  assign idx_bad = (rs1_used & ({1'b0, rs1_f} >= NREG6)) |
                   (rs2_used & ({1'b0, rs2_f} >= NREG6)) |
                   (rd_used  & ({1'b0, rd_f}  >= NREG6));

  triumph_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr_i),
    .itype (itype),
    .imm   (imm)
  );

  assign hazard = ex_load_i & (ex_load_rd_i != '0) &
                  ((rs1_used & (ex_load_rd_i == rs1_a)) |
                   (rs2_used & (ex_load_rd_i == rs2_a)));

  assign id_ready_o = !flush_i & !hazard &
                      ((state == ST_EMPTY) | ex_ready_i);
  assign accept     = if_valid_i & id_ready_o;

  always_comb begin
    dec         = '0;
    dec.pc      = if_pc_i;
    dec.imm     = imm;
    dec.itype   = itype;
    dec.op_type = op_type_f(if_instr_i, itype);
    dec.illegal = !known | (if_instr_i[1:0] != 2'b11) | idx_bad;
    dec.rd      = rd_used ? rd_f[RA_W-1:0] : '0;
    dec.rd_we   = rd_used & (rd_f != 5'd0) & !dec.illegal;
    dec.op1     = (rs1_f == 5'd0) ? '0 : rf_rs1_data_i;
    dec.op2     = (rs2_f == 5'd0) ? '0 : rf_rs2_data_i;
`ifdef TRIUMPH_ID_WB_BYPASS_EN
    if (wb_we_i && wb_rd_i == rs1_a && rs1_f != 5'd0)
      dec.op1 = wb_data_i;
    if (wb_we_i && wb_rd_i == rs2_a && rs2_f != 5'd0)
      dec.op2 = wb_data_i;
`endif
  end

`ifndef TRIUMPH_ID_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_EMPTY;
      entry <= '0;
    end else if (flush_i) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      state <= ST_FULL;
      entry <= dec;
    end else if (ex_ready_i) begin
      state <= ST_EMPTY;
    end
  end

  assign ex_valid_o      = (state == ST_FULL);
  assign ex_pc_o         = entry.pc;
  assign ex_op1_o        = entry.op1;
  assign ex_op2_o        = entry.op2;
  assign ex_imm_o        = entry.imm;
  assign ex_rd_o         = entry.rd;
  assign ex_rd_we_o      = entry.rd_we;
  assign ex_instr_type_o = entry.itype;
  assign ex_op_type_o    = entry.op_type;
  assign ex_illegal_o    = entry.illegal;

endmodule
